// File: rtl/psx_host_poller.sv
// Console-side master for the PSX controller serial link: runs the 5-byte
// read-buttons poll (0x01 0x42 0x00 0x00 0x00) and returns the pad ID and raw buttons.
module psx_host_poller #(
    parameter int CLK_DIV     = 4,
    parameter int ATT_SETUP   = 8,
    parameter int BYTE_GAP    = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter bit IGNORE_ACK  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        psx_clk,
    output logic        att,
    output logic        cmd,
    input  logic        data,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        timeout_err,
    output logic [7:0]  id,
    output logic [15:0] buttons,
    output logic [2:0]  fsm_state
);
    // Handshake: start is a one-cycle request honoured only in IDLE (dropped otherwise);
    // done is a one-cycle pulse, and valid/timeout_err/id/buttons change only with it.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        LOW      = 3'd2,
        HIGH     = 3'd3,
        ACK_WAIT = 3'd4,
        GAP      = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(ATT_SETUP - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(BYTE_GAP - 1);
    localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [7:0]  rx_sr;
    logic [7:0]  id_rx;
    logic [7:0]  sig_rx;
    logic [7:0]  lo_rx;
    logic [7:0]  cur_tx;
    logic [7:0]  nxt_tx;

    function automatic logic [7:0] tx_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    tx_byte = 8'h01;
            3'd1:    tx_byte = 8'h42;
            default: tx_byte = 8'h00;
        endcase
    endfunction

    assign cur_tx    = tx_byte(byte_idx);
    assign nxt_tx    = tx_byte(byte_idx + 3'd1);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            rx_sr       <= '0;
            id_rx       <= '0;
            sig_rx      <= '0;
            lo_rx       <= '0;
            psx_clk     <= 1'b1;
            att         <= 1'b1;
            cmd         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            id          <= 8'h00;
            buttons     <= 16'hFFFF;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        att      <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state   <= LOW;
                        cnt     <= '0;
                        psx_clk <= 1'b0;
                        cmd     <= cur_tx[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LOW: begin
                    if (cnt == DIV_LAST) begin
                        state   <= HIGH;
                        cnt     <= '0;
                        psx_clk <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (cnt == 16'd0) begin
                        rx_sr[bit_idx] <= data;
                    end
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            state   <= LOW;
                            bit_idx <= bit_idx + 3'd1;
                            psx_clk <= 1'b0;
                            cmd     <= cur_tx[bit_idx + 3'd1];
                        end else if (byte_idx == 3'd4) begin
                            // Last byte: no ack follows, publish the result directly.
                            state       <= FINISH;
                            att         <= 1'b1;
                            cmd         <= 1'b1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            valid       <= (sig_rx == 8'h5A);
                            timeout_err <= 1'b0;
                            id          <= id_rx;
                            buttons     <= {rx_sr, lo_rx};
                        end else if (IGNORE_ACK) begin
                            state <= GAP;
                        end else begin
                            state <= ACK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ACK_WAIT: begin
                    if (!ack) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt == ACK_LAST) begin
                        // Abort keeps the previous id/buttons but invalidates them.
                        state       <= FINISH;
                        att         <= 1'b1;
                        cmd         <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        valid       <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == 16'd0) begin
                        case (byte_idx)
                            3'd1:    id_rx  <= rx_sr;
                            3'd2:    sig_rx <= rx_sr;
                            3'd3:    lo_rx  <= rx_sr;
                            default: ;
                        endcase
                    end
                    if (cnt == GAP_LAST) begin
                        state    <= LOW;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        byte_idx <= byte_idx + 3'd1;
                        psx_clk  <= 1'b0;
                        cmd      <= nxt_tx[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psx_host_poller.sv
// Bench for psx_host_poller: one instance with IGNORE_ACK=1 (fake pad), one with ack
// handshaking; a negedge pad responder plus a done-driven scoreboard monitor.
module tb_psx_host_poller;
    localparam int CLK_DIV = 4;
    localparam int W = 27;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ACK_WAIT = 3'd4;

    logic clk;
    logic rst;
    logic [1:0] start;
    logic [1:0] ack_en;
    wire  [1:0] data;
    wire  [1:0] ack;
    wire  [1:0] psx_clk;
    wire  [1:0] att;
    wire  [1:0] cmd;
    wire  [1:0] busy;
    wire  [1:0] done;
    wire  [1:0] valid;
    wire  [1:0] timeout_err;
    wire  [1:0][7:0]  id;
    wire  [1:0][15:0] buttons;
    wire  [1:0][2:0]  fsm_state;

    logic [7:0]   resp [2][5];
    int           exp_falls [2];
    logic [W-1:0] exp_q[$];
    int           chk_cnt = 0;
    int           err_cnt = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    psx_host_poller #(.CLK_DIV(4), .ATT_SETUP(8), .BYTE_GAP(8), .ACK_TIMEOUT(64),
                      .IGNORE_ACK(1'b1)) u_dut_fake (
        .clk(clk), .rst(rst), .start(start[0]), .psx_clk(psx_clk[0]), .att(att[0]),
        .cmd(cmd[0]), .data(data[0]), .ack(ack[0]), .busy(busy[0]), .done(done[0]),
        .valid(valid[0]), .timeout_err(timeout_err[0]), .id(id[0]),
        .buttons(buttons[0]), .fsm_state(fsm_state[0])
    );

    psx_host_poller #(.CLK_DIV(4), .ATT_SETUP(8), .BYTE_GAP(8), .ACK_TIMEOUT(64),
                      .IGNORE_ACK(1'b0)) u_dut_ack (
        .clk(clk), .rst(rst), .start(start[1]), .psx_clk(psx_clk[1]), .att(att[1]),
        .cmd(cmd[1]), .data(data[1]), .ack(ack[1]), .busy(busy[1]), .done(done[1]),
        .valid(valid[1]), .timeout_err(timeout_err[1]), .id(id[1]),
        .buttons(buttons[1]), .fsm_state(fsm_state[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        chk_cnt++;
        if (act !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] exp_cmd(input int idx);
        case (idx)
            0:       exp_cmd = 8'h01;
            1:       exp_cmd = 8'h42;
            default: exp_cmd = 8'h00;
        endcase
    endfunction

    // pad responder: drives data on psx_clk falls, decodes cmd and times the bus
    for (genvar g = 0; g < 2; g++) begin : g_resp
        logic prev_clk, prev_att, data_r, ack_r;
        logic [7:0] cmd_sr;
        int bit_n, fall_cnt, low_len, high_len, ack_cd;
        assign data[g] = data_r;
        assign ack[g]  = ack_r;

        always @(negedge clk) begin
            if (rst) begin
                prev_clk = 1'b1; prev_att = 1'b1; bit_n = 0; fall_cnt = 0; ack_cd = 0;
                low_len = 0; high_len = 0; cmd_sr = '0; data_r = 1'b1; ack_r = 1'b1;
            end else if (att[g]) begin
                if (!prev_att) begin
                    check("att_rise_only_in_finish", 32'(done[g]), 32'd1);
                    check("falling_edges", 32'(fall_cnt), 32'(exp_falls[g]));
                end
                prev_clk = psx_clk[g]; prev_att = 1'b1; bit_n = 0; fall_cnt = 0;
                ack_cd = 0; data_r = 1'b1; ack_r = 1'b1;
            end else begin
                prev_att = 1'b0;
                if (ack_cd > 0) ack_cd--;
                if (prev_clk && !psx_clk[g]) begin
                    if (bit_n % 8 != 0) check("high_len", 32'(high_len), 32'(CLK_DIV));
                    if (bit_n < 40) data_r = resp[g][bit_n / 8][bit_n % 8];
                    fall_cnt++;
                    low_len = 1;
                end else if (!prev_clk && psx_clk[g]) begin
                    check("low_len", 32'(low_len), 32'(CLK_DIV));
                    cmd_sr[bit_n % 8] = cmd[g];
                    if (bit_n % 8 == 7) begin
                        check("cmd_byte", 32'(cmd_sr), 32'(exp_cmd(bit_n / 8)));
                        if (bit_n / 8 < 4 && ack_en[g]) ack_cd = 12;
                    end
                    bit_n++;
                    high_len = 1;
                end else if (psx_clk[g]) begin
                    high_len++;
                end else begin
                    low_len++;
                end
                ack_r = (ack_cd == 1 || ack_cd == 2) ? 1'b0 : 1'b1;
                if (fsm_state[g] == ST_ACK_WAIT)
                    check("clk_idle_in_ack_wait", 32'(psx_clk[g]), 32'd1);
                prev_clk = psx_clk[g];
            end
        end
    end

    // scoreboard monitor: every done pops one expected result
    always @(negedge clk) begin
        logic [W-1:0] e;
        for (int g = 0; g < 2; g++) begin
            if (done[g] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_done: inst %0d pulsed done, none expected", g);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_inst", 32'(g), 32'(e[26]));
                    check("mon_valid", 32'(valid[g]), 32'(e[25]));
                    check("mon_timeout_err", 32'(timeout_err[g]), 32'(e[24]));
                    check("mon_id", 32'(id[g]), 32'(e[23:16]));
                    check("mon_buttons", 32'(buttons[g]), 32'(e[15:0]));
                    check("mon_busy_low", 32'(busy[g]), 32'd0);
                    check("mon_idle_lines", 32'({att[g], psx_clk[g], cmd[g]}), 32'h7);
                end
            end
        end
    end

    task automatic check_reset(input int g);
        check("rst_lines", 32'({psx_clk[g], att[g], cmd[g]}), 32'h7);
        check("rst_busy_done", 32'({busy[g], done[g]}), 32'h0);
        check("rst_valid_terr", 32'({valid[g], timeout_err[g]}), 32'h0);
        check("rst_id", 32'(id[g]), 32'h00);
        check("rst_buttons", 32'(buttons[g]), 32'hFFFF);
        check("rst_state", 32'(fsm_state[g]), 32'(ST_IDLE));
    endtask

    // driver: one poll; called #1 after a posedge
    task automatic poll(input int g, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4,
                        input logic e_valid, input logic e_terr, input logic [7:0] e_id,
                        input logic [15:0] e_btn, input int e_cyc, input int e_falls,
                        input int mid_start, input int rst_at, input bit start_at_done);
        int cyc;
        bit seen;
        bit aborted;
        resp[g][0] = 8'hFF; resp[g][1] = b1; resp[g][2] = b2; resp[g][3] = b3; resp[g][4] = b4;
        exp_falls[g] = e_falls;
        if (rst_at == 0) exp_q.push_back({1'(g), e_valid, e_terr, e_id, e_btn});
        start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
        check("busy_after_start", 32'(busy[g]), 32'd1);
        check("att_after_start", 32'(att[g]), 32'd0);
        cyc = 0; seen = 1'b0; aborted = 1'b0;
        while (!seen && !aborted && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start[g] = (mid_start != 0 && cyc == mid_start);
            if (done[g]) seen = 1'b1;
            else if (rst_at != 0 && cyc == rst_at) aborted = 1'b1;
        end
        if (aborted) begin
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1;
            check_reset(g);
            rst = 1'b0;
        end else if (seen) begin
            check("poll_cycles", 32'(cyc), 32'(e_cyc));
            if (start_at_done) begin
                start[g] = 1'b1;
                @(posedge clk); #1 start[g] = 1'b0;
                check("start_at_done_ignored", 32'(busy[g]), 32'd0);
            end
        end else begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL poll_timeout: inst %0d no done within %0d cycles", g, cyc);
        end
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_poll", 32'({busy[g], att[g]}), 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        start = 2'b00;
        ack_en = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(posedge clk); #1;
        // fake pad defaults, ack ignored
        poll(0, 8'h41, 8'h5A, 8'h7F, 8'hBF, 1'b1, 1'b0, 8'h41, 16'hBF7F, 361, 40, 0, 0, 1'b0);
        // ack pulsed 10 cycles after bytes 0-3
        ack_en[1] = 1'b1;
        poll(1, 8'h41, 8'h5A, 8'h12, 8'h34, 1'b1, 1'b0, 8'h41, 16'h3412, 389, 40, 0, 0, 1'b0);
        // ack never arrives: abort after byte 0, previous id/buttons kept
        ack_en[1] = 1'b0;
        poll(1, 8'h41, 8'h5A, 8'h12, 8'h34, 1'b0, 1'b1, 8'h41, 16'h3412, 137, 8, 0, 0, 1'b0);
        // bad signature byte, plus start in the done cycle
        ack_en[1] = 1'b1;
        poll(1, 8'h73, 8'h00, 8'hAA, 8'h55, 1'b0, 1'b0, 8'h73, 16'h55AA, 389, 40, 0, 0, 1'b1);
        // reset during byte 3, then a clean poll with a stray start while busy
        poll(0, 8'h41, 8'h5A, 8'hFE, 8'hEF, 1'b0, 1'b0, 8'h00, 16'hFFFF, 0, 0, 0, 244, 1'b0);
        poll(0, 8'h41, 8'h5A, 8'hFE, 8'hEF, 1'b1, 1'b0, 8'h41, 16'hEFFE, 361, 40, 100, 0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
